// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: 8N1 frame on tx_pin, triggered by a rising edge of tx_start.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_pin,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cfg
    $error("uart_tx_serializer: CLK_FREQ / BAUD_RATE must be at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             pin_q, pin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic rise_s;
  logic cnt_last_s;

  assign rise_s     = tx_start & ~start_q;
  assign cnt_last_s = (cnt_q == CNT_LAST);

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    start_d = tx_start;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pin_d   = pin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rise_s) begin
          state_d = S_START;
          shift_d = tx_data;
          cnt_d   = '0;
          idx_d   = 3'd0;
          pin_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(tx_data);
`endif
        end else begin
          pin_d  = 1'b1;
          busy_d = 1'b0;
        end
      end

      S_START: begin
        if (cnt_last_s) begin
          state_d = S_DATA;
          cnt_d   = '0;
          pin_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_last_s) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            pin_d   = parity_q;
`else
            state_d = S_STOP;
            pin_d   = 1'b1;
`endif
          end else begin
            // Shift right so the next bit to send is always at shift_q[0].
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            pin_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_last_s) begin
          state_d = S_STOP;
          cnt_d   = '0;
          pin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt_last_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pin_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pin_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the idle line level immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      shift_q <= 8'h00;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      pin_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_pin  = pin_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer that turns a memory-mapped transmit request into an 8N1 serial frame on `tx_pin`. It sits directly downstream of the `tx` start register and `tx_data` register in the SoC top. It consumes their bit 0 and bits 7:0 respectively, and runs on the fast system clock. The CPU-side registers hold levels, so the block acts on the rising edge of `tx_start` and never retransmits on a held level.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate in bits/s.
- `CLKS_PER_BIT` (localparam): CLK_FREQ / BAUD_RATE, integer division (434 at defaults). The value must be ≥ 2; elaboration fails otherwise.
- Ports:
  - `clk` input, 1: system clock. All logic is on its rising edge.
  - `reset` input, 1: asynchronous, active-high reset.
  - `tx_start` input, 1: transmit request level. A 0→1 transition starts a frame.
  - `tx_data` input, 8: byte to send. Sampled on the accepted start edge.
  - `tx_pin` output, 1: serial line. Idles high.
  - `tx_busy` output, 1: high while a frame is in flight.
  - `tx_done` output, 1: one-cycle pulse when the stop bit completes.

## Operation
- Edge detect: register `start_q` holds the previous value of `tx_start` and resets to 0. A rise is `tx_start & ~start_q`. If `tx_start` is already high when reset releases, the first clock edge counts as a rise.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - Outputs: `tx_pin`=1, `tx_busy`=0.
  - On a rise, latch `tx_data` into the shift register, clear the bit counter (`CLKS_PER_BIT`-wide, $clog2) and the bit index (3 bits), and go to START.
- START: drive `tx_pin`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Bits are sent LSB first. Each bit is held for CLKS_PER_BIT cycles.
  - After bit 7, go to PARITY if the macro is defined, otherwise to STOP.
- STOP:
  - Drive `tx_pin`=1 for CLKS_PER_BIT cycles.
  - On the final cycle, assert `tx_done` for one cycle and return to IDLE.
- `tx_busy`=1 in every state other than IDLE.
- Rises that arrive while not in IDLE are ignored, not queued. `start_q` still tracks `tx_start`, so such a rise is lost.
- `tx_data` changes after the start edge have no effect on the frame in flight.
- All outputs are registered. No combinational path exists from any input to any output.

## Timing
- Reset values (immediate, asynchronous): `tx_pin`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, `start_q`=0. A reset mid-frame returns `tx_pin` to 1 immediately, without waiting for a clock. The partial frame is discarded.
- Frame timing, with k = the edge at which the rise is sampled and C = CLKS_PER_BIT:
  - From edge k: `tx_pin`=0 and `tx_busy`=1.
  - Data bit i appears from edge k+C·(1+i), for i = 0..7.
  - Stop bit appears from edge k+9C.
  - At edge k+10C: `tx_done`=1 for exactly one cycle, and `tx_busy`=0.
- The earliest next accepted rise is sampled at edge k+10C+1. `tx_start` must have been observed low for at least one cycle beforehand.
- Frame length: 10 bit-times (11 with parity).

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: insert an even-parity bit (XOR of the 8 latched data bits) after bit 7, held for C cycles. Stop starts at k+10C and `tx_done` fires at k+11C.
  - Undefined: pure 8N1. No PARITY state or parity logic is built.

## Test plan
All scenarios use CLK_FREQ=8, BAUD_RATE=1, so C=8.
- Basic frame: reset, then raise `tx_start` with `tx_data`=8'hA5.
  - `tx_pin` shows 0, then 1,0,1,0,0,1,0,1, then 1, each level for exactly 8 cycles.
  - `tx_done` pulses once, 80 cycles after the start edge. `tx_busy` is high for exactly those 80 cycles.
- Held level: keep `tx_start`=1 for 200 cycles with 8'h3C.
  - Exactly one frame is sent. `tx_pin` stays 1 after the stop bit and `tx_done` pulses once.
- Busy collision: after a frame starts with 8'h55, drop `tx_start` at cycle 20, re-raise it at cycle 30, and change `tx_data` to 8'hFF.
  - The 8'h55 frame is unaltered. No second frame is sent.
- Back-to-back: drop `tx_start` on the cycle `tx_done` pulses, then raise it one cycle later with 8'h00.
  - The second start bit begins 2 cycles after the first `tx_done`. Both frames are correct.
- Reset mid-frame: assert `reset` asynchronously during bit 3 of 8'h0F.
  - `tx_pin`=1, `tx_busy`=0 and `tx_done`=0 immediately. After release, an 8'h81 request transmits correctly.
- Parity build (`UART_TX_PARITY_EN`): send 8'h07, then 8'h03.
  - The parity bit is 1 for 8'h07 and 0 for 8'h03. `tx_done` fires at 88 cycles.
